seq_digit_adder: RTL and testbench

Multi-cycle, digit-serial unsigned adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through a registered carry chain.
- Successor to the team's 1-bit full adder: parametrised width, digit size and valid/ready handshakes.
- Sits between operand registers and result consumers where area matters more than latency.

---
 rtl/seq_digit_adder_pkg.sv | 21 ++
 rtl/seq_digit_adder_digit.sv | 23 ++
 rtl/seq_digit_adder.sv | 111 +++++++++++
 tb/tb_seq_digit_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_digit_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package seq_digit_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Step counter never narrower than one bit, even for a single-step build.
    function automatic int calc_cnt_w(input int width, input int digit);
        int steps;
        steps = width / digit;
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/seq_digit_adder_digit.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/seq_digit_adder.sv
// Digit-serial unsigned adder: {cout,sum} = a + b + cin, DIGIT bits per clock.
// Define SEQ_DIGIT_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_digit_adder
    import seq_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_DIGIT_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_cfg
        $error("seq_digit_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_reg;
    logic [CNT_W-1:0] step;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic [DIGIT-1:0] d_s;
    logic             d_co;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x  (a_sh[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .ci (carry_reg),
        .s  (d_s),
        .co (d_co)
    );

`ifdef SEQ_DIGIT_ADDER_OVF_EN
    logic ovf_reg;
    logic c_msb;
    // Carry into the digit's top bit, recovered from its sum and inputs.
    assign c_msb = d_s[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    assign ovf   = ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry_reg <= 1'b0;
            step      <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
`ifdef SEQ_DIGIT_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_reg <= cin;
                        step      <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[int'(step) * DIGIT +: DIGIT] <= d_s;
                    carry_reg <= d_co;
                    a_sh      <= a_sh >> DIGIT;
                    b_sh      <= b_sh >> DIGIT;
                    step      <= step + CNT_W'(1);
                    if (step == LAST_STEP) begin
                        cout_reg <= d_co;
`ifdef SEQ_DIGIT_ADDER_OVF_EN
                        ovf_reg  <= c_msb ^ d_co;
`endif
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_seq_digit_adder.sv
// Directed-vector bench for seq_digit_adder (WIDTH=16, DIGIT set by DIG).
`timescale 1ns/1ps
module tb_seq_digit_adder;

    parameter int DIG = 4;
    localparam int W     = 16;
    localparam int STEPS = W / DIG;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SEQ_DIGIT_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];

    seq_digit_adder #(.WIDTH(W), .DIGIT(DIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SEQ_DIGIT_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ovf_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W-1:0] low;
        logic [W:0]   full;
        low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, c};
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return low[W-1] ^ full[W];
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_c,
                          input logic exp_ovf, input int hold);
        int         lat;
        logic [W:0] exp;
        exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c});
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = op_a;
        b = op_b;
        cin = op_c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, STEPS);
        exp = exp_q.pop_front();
        check("result", {15'd0, cout, sum}, {15'd0, exp});
`ifdef SEQ_DIGIT_ADDER_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("unexpected x in ovf reference");
`endif
        if (hold > 0) begin
            in_valid = 1'b1;
            a = 16'h0F0F;
            b = 16'h0101;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_result", {15'd0, cout, sum}, {15'd0, exp});
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic reset_mid_run();
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (STEPS > 2) begin
            repeat (2) @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", {15'd0, cout, sum}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (2 * STEPS + 2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {15'd0, cout, sum}, 32'd0);
`ifdef SEQ_DIGIT_ADDER_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed vectors: a, b, cin, expected ovf.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);   // 0x05555
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);   // 0x10000
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);   // 0x1FFFF
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 0);   // 0x10000, full ripple
        run_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 0);   // 0x01000
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);   // 0x00001
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0);   // 0x08000
        run_op(16'h8000, 16'hFFFF, 1'b0, 1'b1, 0);   // 0x17FFF
        run_op(16'h0001, 16'hFFFF, 1'b0, 1'b0, 0);   // 0x10000

        // Backpressure with competing in_valid.
        run_op(16'h1357, 16'h2468, 1'b0, 1'b0, 10);  // 0x037BF

        reset_mid_run();
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);   // 0x00002

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, ovf_model(ra, rb, rc), (i % 17 == 0) ? 2 : 0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
